// File: rtl/convergence_check.sv
// Two-stage Manhattan-distance check of new vs. old centroids; writes each new centroid back
// and reports convergence once centroid_num results have been processed since the last clear.
module convergence_check #(
  parameter int centroid_num    = 8,
  parameter int log2_cent_num   = 3,
  parameter int coord_num       = 7,
  parameter int cordinate_width = 13,
  parameter int manhatten_width = 16,
  parameter int conv_threshold  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 convergence_reg_en,
  input  logic                                 convergence_regs_reset_n,
  input  logic                                 cent_valid,
  input  logic [log2_cent_num-1:0]             cent_idx,
  input  logic [coord_num*cordinate_width-1:0] new_cent,
  input  logic [coord_num*cordinate_width-1:0] old_cent,
  output logic [coord_num*cordinate_width-1:0] wr_cent,
  output logic [centroid_num-1:0]              wr_cent_en,
  output logic [log2_cent_num-1:0]             wr_cnvrg_to_calc_cent_num,
  output logic                                 converge_res_available,
  output logic                                 has_converged
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam int CNT_W = log2_cent_num + 1;

  logic [1:0]                           state;
  logic                                 accept;
  logic [cordinate_width-1:0]           diff_c [coord_num];
  logic [cordinate_width-1:0]           s1_diff [coord_num];
  logic                                 s1_vld;
  logic [coord_num*cordinate_width-1:0] s1_new;
  logic [log2_cent_num-1:0]             s1_idx;
  logic [manhatten_width-1:0]           sum_c;
  logic                                 close_c;
  logic [centroid_num-1:0]              onehot_c;
  logic [CNT_W-1:0]                     cnt;
  logic [CNT_W-1:0]                     cnt_nxt;
  logic                                 last_c;
  logic                                 all_close;

  assign accept = cent_valid & convergence_reg_en & convergence_regs_reset_n & (state != DONE);

  always_comb begin
    for (int k = 0; k < coord_num; k++) begin
      diff_c[k] = (new_cent[k*cordinate_width +: cordinate_width] >= old_cent[k*cordinate_width +: cordinate_width])
                ? new_cent[k*cordinate_width +: cordinate_width] - old_cent[k*cordinate_width +: cordinate_width]
                : old_cent[k*cordinate_width +: cordinate_width] - new_cent[k*cordinate_width +: cordinate_width];
    end
  end

  // Second stage adds the registered differences; the total never exceeds manhatten_width bits.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < coord_num; k++) begin
      sum_c = sum_c + manhatten_width'(s1_diff[k]);
    end
    close_c  = (sum_c <= manhatten_width'(conv_threshold));
    onehot_c = '0;
    onehot_c[s1_idx] = 1'b1;
    cnt_nxt  = cnt + CNT_W'(1);
    last_c   = (cnt_nxt == CNT_W'(centroid_num));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_new <= '0;
      s1_idx <= '0;
      for (int k = 0; k < coord_num; k++) s1_diff[k] <= '0;
    end else if (!convergence_regs_reset_n) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_diff <= diff_c;
        s1_new  <= new_cent;
        s1_idx  <= cent_idx;
      end
    end
  end

  // Count and all_close update on the same edge as the write-back so the verdict lands at N+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      cnt                       <= '0;
      all_close                 <= 1'b1;
      wr_cent                   <= '0;
      wr_cent_en                <= '0;
      wr_cnvrg_to_calc_cent_num <= '0;
      converge_res_available    <= 1'b0;
      has_converged             <= 1'b0;
    end else if (!convergence_regs_reset_n) begin
      state                  <= IDLE;
      cnt                    <= '0;
      all_close              <= 1'b1;
      wr_cent_en             <= '0;
      converge_res_available <= 1'b0;
      has_converged          <= 1'b0;
    end else begin
      wr_cent_en <= '0;
      if (accept && state == IDLE) state <= COLLECT;
      if (s1_vld) begin
        wr_cent                   <= s1_new;
        wr_cent_en                <= onehot_c;
        wr_cnvrg_to_calc_cent_num <= s1_idx;
        if (state != DONE) begin
          cnt       <= cnt_nxt;
          all_close <= all_close & close_c;
          if (last_c) begin
            state                  <= DONE;
            converge_res_available <= 1'b1;
            has_converged          <= all_close & close_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_convergence_check.sv
// Scoreboard bench: stimulus pushes expected write-backs, a negedge monitor pops and compares.
module tb_convergence_check;
  localparam int CW = 13;
  localparam int CN = 7;
  localparam int W  = CW * CN;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         reg_en = 1'b0;
  logic         clr_n = 1'b1;
  logic         cv = 1'b0;
  logic [2:0]   idx = '0;
  logic [W-1:0] nc = '0;
  logic [W-1:0] oc = '0;
  logic [W-1:0] wr_cent;
  logic [7:0]   wr_cent_en;
  logic [2:0]   wr_idx;
  logic         avail;
  logic         has_conv;

  convergence_check dut (
    .clk(clk), .rst_n(rst_n),
    .convergence_reg_en(reg_en), .convergence_regs_reset_n(clr_n),
    .cent_valid(cv), .cent_idx(idx), .new_cent(nc), .old_cent(oc),
    .wr_cent(wr_cent), .wr_cent_en(wr_cent_en), .wr_cnvrg_to_calc_cent_num(wr_idx),
    .converge_res_available(avail), .has_converged(has_conv)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [2:0]   idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rise_cyc = -1;
  logic avail_prev = 1'b0;
  int   last;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (avail && !avail_prev) rise_cyc = cyc;
    avail_prev = avail;
    if (rst_n && wr_cent_en != 8'd0) begin
      if (q.size() == 0) begin
        chk("unexpected_wb", {120'd0, wr_cent_en}, 128'd0);
      end else begin
        mon_e = q.pop_front();
        chk("wb_cycle", cyc, mon_e.cyc);
        chk("wb_en", {120'd0, wr_cent_en}, {120'd0, 8'd1 << mon_e.idx});
        chk("wb_idx", {125'd0, wr_idx}, {125'd0, mon_e.idx});
        chk("wb_data", wr_cent, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] old_of(input int i);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < CN; k++) v[k*CW +: CW] = CW'(200 + i*64 + k*9);
    return v;
  endfunction

  task automatic send(input int i, input logic [W-1:0] n, input logic [W-1:0] o,
                      input logic en, input bit exp_wb);
    exp_t e;
    cv = 1'b1; reg_en = en; idx = 3'(i); nc = n; oc = o;
    if (exp_wb) begin
      e.cyc = cyc + 2; e.idx = 3'(i); e.data = n;
      q.push_back(e);
    end
    step();
    cv = 1'b0; reg_en = 1'b1;
  endtask

  // mode 0: all equal; 1: idx3 +16 on one coord; 2: idx3 -17 on one coord; 3: idx5 +/-3 on all coords
  task automatic run8(input int mode, output int last_cyc);
    logic [W-1:0] o, n;
    rise_cyc = -1;
    last_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      o = old_of(i);
      n = o;
      if (mode == 1 && i == 3) n[2*CW +: CW] = o[2*CW +: CW] + CW'(16);
      if (mode == 2 && i == 3) n[0 +: CW] = o[0 +: CW] - CW'(17);
      if (mode == 3 && i == 5)
        for (int k = 0; k < CN; k++)
          n[k*CW +: CW] = (k % 2 == 0) ? o[k*CW +: CW] + CW'(3) : o[k*CW +: CW] - CW'(3);
      last_cyc = cyc;
      send(i, n, o, 1'b1, 1'b1);
    end
  endtask

  task automatic wait_result(input string name, input int exp_cyc, input logic exp_conv);
    int n;
    n = 0;
    while (!avail && n < 40) begin
      step();
      n++;
    end
    if (!avail) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=0 expected=1", name);
    end else begin
      @(negedge clk);
      #1;
      chk({name, "_cycle"}, rise_cyc, exp_cyc);
      chk({name, "_conv"}, {127'd0, has_conv}, {127'd0, exp_conv});
      step();
    end
  endtask

  task automatic drained(input string name);
    repeat (3) step();
    chk(name, q.size(), 0);
  endtask

  task automatic clear();
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    chk("clr_avail", {127'd0, avail}, 128'd0);
    chk("clr_conv", {127'd0, has_conv}, 128'd0);
    chk("clr_en", {120'd0, wr_cent_en}, 128'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_cent"}, wr_cent, 128'd0);
    chk({tag, "_wr_en"}, {120'd0, wr_cent_en}, 128'd0);
    chk({tag, "_wr_idx"}, {125'd0, wr_idx}, 128'd0);
    chk({tag, "_avail"}, {127'd0, avail}, 128'd0);
    chk({tag, "_conv"}, {127'd0, has_conv}, 128'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    reg_en = 1'b1;

    run8(0, last);
    wait_result("converged", last + 2, 1'b1);
    drained("converged_drain");

    send(0, ~old_of(0), old_of(0), 1'b1, 1'b0);
    repeat (3) step();
    chk("done_hold_avail", {127'd0, avail}, 128'd1);
    chk("done_hold_conv", {127'd0, has_conv}, 128'd1);
    drained("done_ignore_drain");

    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    run8(1, last);
    wait_result("thr16", last + 2, 1'b1);
    drained("thr16_drain");
    clear();

    run8(2, last);
    wait_result("thr17", last + 2, 1'b0);
    drained("thr17_drain");
    clear();

    run8(3, last);
    wait_result("multi", last + 2, 1'b0);
    drained("multi_drain");
    clear();

    // fourth sample is still in stage 1 when the clear lands, so its write-back is flushed
    rise_cyc = -1;
    for (int i = 0; i < 4; i++) send(i, old_of(i), old_of(i), 1'b1, i < 3);
    cv = 1'b1; idx = 3'd4; nc = ~old_of(4); oc = old_of(4); clr_n = 1'b0;
    step();
    cv = 1'b0; clr_n = 1'b1;
    chk("midclr_en", {120'd0, wr_cent_en}, 128'd0);
    chk("midclr_avail", {127'd0, avail}, 128'd0);
    repeat (4) step();
    chk("midclr_noresult", {127'd0, avail}, 128'd0);
    drained("midclr_drain");
    run8(0, last);
    wait_result("midclr_fresh", last + 2, 1'b1);
    drained("midclr_fresh_drain");
    clear();

    rise_cyc = -1;
    for (int i = 0; i < 4; i++) send(i, old_of(i), old_of(i), 1'b1, 1'b1);
    send(4, ~old_of(4), old_of(4), 1'b0, 1'b0);
    step();
    for (int i = 4; i < 8; i++) begin
      last = cyc;
      send(i, old_of(i), old_of(i), 1'b1, 1'b1);
    end
    wait_result("gap", last + 2, 1'b1);
    drained("gap_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
